// File: rtl/pipe_adder.sv
// Pipelined carry-chained adder/subtractor with valid/ready handshake and a global stall.
// Optional signed-overflow output oOvf is built when PIPE_ADDER_OVF_EN is defined.
module pipe_adder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iC,
  input  logic             iSub,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  output logic             oData_C
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             oOvf
`endif
);

  localparam int unsigned Chunk = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] eff_b;

  assign advance = !oValid || iReady;
  assign oReady  = advance;
  assign eff_b   = iSub ? ~iData_b : iData_b;

  // Stage k sees only the operand bits it has not consumed yet (its chunk sits at the bottom)
  // and holds the (k+1) completed low chunks of the sum.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned InW  = WIDTH - k * Chunk;
    localparam int unsigned SumW = (k + 1) * Chunk;

    logic [InW-1:0]  a_in;
    logic [InW-1:0]  b_in;
    logic            c_in;
    logic            v_in;
    logic [Chunk:0]  chunk_sum;
    logic [SumW-1:0] sum_d;
    logic [SumW-1:0] sum_q;
    logic            c_q;
    logic            v_q;

    if (k == 0) begin : g_first
      assign a_in  = iData_a;
      assign b_in  = eff_b;
      assign c_in  = iC;
      assign v_in  = iValid;
      assign sum_d = chunk_sum[Chunk-1:0];
    end else begin : g_next
      assign a_in  = g_stage[k-1].g_mid.a_q;
      assign b_in  = g_stage[k-1].g_mid.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign sum_d = {chunk_sum[Chunk-1:0], g_stage[k-1].sum_q};
    end

    assign chunk_sum = {1'b0, a_in[Chunk-1:0]} + {1'b0, b_in[Chunk-1:0]} +
                       {{Chunk{1'b0}}, c_in};

    always_ff @(posedge iClk) begin
      if (iRst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= v_in;
        c_q   <= chunk_sum[Chunk];
        sum_q <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic [InW-Chunk-1:0] a_q;
      logic [InW-Chunk-1:0] b_q;

      always_ff @(posedge iClk) begin
        if (iRst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[InW-1:Chunk];
          b_q <= b_in[InW-1:Chunk];
        end
      end
    end

`ifdef PIPE_ADDER_OVF_EN
    // Last stage still sees the original operand MSBs at the top of its chunk.
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;

      always_ff @(posedge iClk) begin
        if (iRst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (a_in[Chunk-1] == b_in[Chunk-1]) && (chunk_sum[Chunk-1] != a_in[Chunk-1]);
        end
      end
    end
`endif
  end

  assign oValid  = g_stage[STAGES-1].v_q;
  assign oData   = g_stage[STAGES-1].sum_q;
  assign oData_C = g_stage[STAGES-1].c_q;

`ifdef PIPE_ADDER_OVF_EN
  assign oOvf = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: WIDTH=8 with STAGES=1, 2 and 8 sharing one stimulus.
// Overflow checks are compiled in when PIPE_ADDER_OVF_EN is defined.
module tb_pipe_adder;

  logic       clk = 1'b0;
  logic       rst, valid, cin, sub, rdy;
  logic [7:0] a, b;
  logic       r1, v1, c1, r2, v2, c2, r8, v8, c8;
  logic [7:0] d1, d2, d8;
`ifdef PIPE_ADDER_OVF_EN
  logic       ovf1, ovf2, ovf8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .iClk(clk), .iRst(rst), .iValid(valid), .oReady(r1), .iData_a(a), .iData_b(b),
    .iC(cin), .iSub(sub), .oValid(v1), .iReady(rdy), .oData(d1), .oData_C(c1)
`ifdef PIPE_ADDER_OVF_EN
    , .oOvf(ovf1)
`endif
  );

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut (
    .iClk(clk), .iRst(rst), .iValid(valid), .oReady(r2), .iData_a(a), .iData_b(b),
    .iC(cin), .iSub(sub), .oValid(v2), .iReady(rdy), .oData(d2), .oData_C(c2)
`ifdef PIPE_ADDER_OVF_EN
    , .oOvf(ovf2)
`endif
  );

  pipe_adder #(.WIDTH(8), .STAGES(8)) u_dut8 (
    .iClk(clk), .iRst(rst), .iValid(valid), .oReady(r8), .iData_a(a), .iData_b(b),
    .iC(cin), .iSub(sub), .oValid(v8), .iReady(rdy), .oData(d8), .oData_C(c8)
`ifdef PIPE_ADDER_OVF_EN
    , .oOvf(ovf8)
`endif
  );

  // {ovf, carry, sum} reference
  function automatic logic [9:0] ref_add(input logic [7:0] fa, input logic [7:0] fb,
                                         input logic fc, input logic fs);
    logic [7:0] eb;
    logic [8:0] s;
    eb = fs ? ~fb : fb;
    s  = {1'b0, fa} + {1'b0, eb} + {8'd0, fc};
    return {(fa[7] == eb[7]) && (s[7] != fa[7]), s};
  endfunction

  task automatic cycle_start;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts);
    valid = 1'b1;
    a     = ta;
    b     = tb;
    cin   = tc;
    sub   = ts;
  endtask

  task automatic do_reset;
    cycle_start();
    rst   = 1'b1;
    valid = 1'b0;
    cycle_start();
    cycle_start();
    rst = 1'b0;
    rdy = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rdy = 1'b0;
    set_op(8'hFF, 8'h01, 1'b0, 1'b0);
    cycle_start();
    cycle_start();
    @(negedge clk);
    checks++;
    if (v2 !== 1'b0 || d2 !== 8'h00 || c2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h c=%b want v=0 d=00 c=0", v2, d2, c2);
    end
    cycle_start();
    rst   = 1'b0;
    valid = 1'b0;
    rdy   = 1'b1;
    @(negedge clk);
    checks++;
    if (r2 !== 1'b1 || r1 !== 1'b1 || r8 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b%b%b want 111", r1, r2, r8);
    end
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b0 || v8 !== 1'b0) begin
      errors++;
      $display("FAIL valid_ignored_in_reset: got %b%b%b want 000", v1, v2, v8);
    end
  endtask

  task automatic test_add;
    cycle_start();
    set_op(8'h3C, 8'h15, 1'b0, 1'b0);
    @(negedge clk);
    cycle_start();
    valid = 1'b0;
    @(negedge clk);
    checks++;
    if (v2 !== 1'b0) begin
      errors++;
      $display("FAIL add_latency_early: got v=%b want 0", v2);
    end
    checks++;
    if (v1 !== 1'b1 || d1 !== 8'h51 || c1 !== 1'b0) begin
      errors++;
      $display("FAIL add_stage1: got v=%b d=%h c=%b want v=1 d=51 c=0", v1, d1, c1);
    end
    cycle_start();
    @(negedge clk);
    checks++;
    if (v2 !== 1'b1 || d2 !== 8'h51 || c2 !== 1'b0) begin
      errors++;
      $display("FAIL add_basic: got v=%b d=%h c=%b want v=1 d=51 c=0", v2, d2, c2);
    end
    cycle_start();
    @(negedge clk);
    checks++;
    if (v2 !== 1'b0) begin
      errors++;
      $display("FAIL add_bubble: got v=%b want 0", v2);
    end
  endtask

  task automatic test_wrap;
    cycle_start();
    set_op(8'hFF, 8'h01, 1'b0, 1'b0);
    cycle_start();
    set_op(8'h7F, 8'h01, 1'b0, 1'b0);
    cycle_start();
    valid = 1'b0;
    @(negedge clk);
    checks++;
    if (v2 !== 1'b1 || d2 !== 8'h00 || c2 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ones: got v=%b d=%h c=%b want v=1 d=00 c=1", v2, d2, c2);
    end
`ifdef PIPE_ADDER_OVF_EN
    checks++;
    if (ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ones_ovf: got %b want 0", ovf2);
    end
`endif
    cycle_start();
    @(negedge clk);
    checks++;
    if (v2 !== 1'b1 || d2 !== 8'h80 || c2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_signed: got v=%b d=%h c=%b want v=1 d=80 c=0", v2, d2, c2);
    end
`ifdef PIPE_ADDER_OVF_EN
    checks++;
    if (ovf2 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_signed_ovf: got %b want 1", ovf2);
    end
`endif
    cycle_start();
  endtask

  task automatic test_sub;
    cycle_start();
    set_op(8'h10, 8'h20, 1'b1, 1'b1);
    cycle_start();
    set_op(8'h20, 8'h10, 1'b1, 1'b1);
    cycle_start();
    valid = 1'b0;
    @(negedge clk);
    checks++;
    if (v2 !== 1'b1 || d2 !== 8'hF0 || c2 !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: got v=%b d=%h c=%b want v=1 d=f0 c=0", v2, d2, c2);
    end
    cycle_start();
    @(negedge clk);
    checks++;
    if (v2 !== 1'b1 || d2 !== 8'h10 || c2 !== 1'b1) begin
      errors++;
      $display("FAIL sub_noborrow: got v=%b d=%h c=%b want v=1 d=10 c=1", v2, d2, c2);
    end
    cycle_start();
  endtask

  task automatic test_back_to_back_stall;
    logic [7:0] va [4] = '{8'h01, 8'h80, 8'hAA, 8'h0F};
    logic [7:0] vb [4] = '{8'h02, 8'h80, 8'h55, 8'h70};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [8:0] res [4] = '{9'h003, 9'h100, 9'h155, 9'h080};
    int in_idx  = 0;
    int out_idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      cycle_start();
      if (in_idx < 4) set_op(va[in_idx], vb[in_idx], vc[in_idx], vs[in_idx]);
      else valid = 1'b0;
      rdy = !(cyc >= 2 && cyc <= 4);
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (r2 !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready cyc%0d: got %b want 0", cyc, r2);
        end
        checks++;
        if (v2 !== 1'b1 || {c2, d2} !== res[0]) begin
          errors++;
          $display("FAIL stall_hold cyc%0d: got v=%b %h want v=1 %h", cyc, v2, {c2, d2}, res[0]);
        end
      end
      if (v2 && rdy) begin
        checks++;
        if (out_idx >= 4) begin
          errors++;
          $display("FAIL stall_extra: got %h want none", {c2, d2});
        end else if ({c2, d2} !== res[out_idx]) begin
          errors++;
          $display("FAIL stall_order%0d: got %h want %h", out_idx, {c2, d2}, res[out_idx]);
        end
        out_idx++;
      end
      if (valid && r2) in_idx++;
    end
    checks++;
    if (out_idx != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d want 4", out_idx);
    end
  endtask

  task automatic test_reset_in_flight;
    rdy = 1'b0;
    cycle_start();
    set_op(8'h11, 8'h22, 1'b0, 1'b0);
    cycle_start();
    set_op(8'h33, 8'h44, 1'b0, 1'b0);
    cycle_start();
    rst = 1'b1;
    set_op(8'h55, 8'h66, 1'b0, 1'b0);
    cycle_start();
    rst   = 1'b0;
    valid = 1'b0;
    rdy   = 1'b1;
    @(negedge clk);
    checks++;
    if (v2 !== 1'b0 || d2 !== 8'h00 || c2 !== 1'b0 || r2 !== 1'b1) begin
      errors++;
      $display("FAIL flight_reset: got v=%b d=%h c=%b r=%b want v=0 d=00 c=0 r=1",
               v2, d2, c2, r2);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      cycle_start();
      @(negedge clk);
      checks++;
      if (v1 !== 1'b0 || v2 !== 1'b0 || v8 !== 1'b0) begin
        errors++;
        $display("FAIL flight_stale cyc%0d: got %b%b%b want 000", cyc, v1, v2, v8);
      end
    end
  endtask

  task automatic test_latency;
    int lat1 = -1;
    int lat2 = -1;
    int lat8 = -1;
    do_reset();
    set_op(8'hC3, 8'h5A, 1'b1, 1'b0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (v1 && lat1 < 0) lat1 = cyc;
      if (v2 && lat2 < 0) lat2 = cyc;
      if (v8 && lat8 < 0) lat8 = cyc;
      cycle_start();
      valid = 1'b0;
    end
    checks++;
    if (lat1 != 1 || lat2 != 2 || lat8 != 8) begin
      errors++;
      $display("FAIL latency: got %0d/%0d/%0d want 1/2/8", lat1, lat2, lat8);
    end
    checks++;
    if ({c8, d8} !== 9'h11E) begin
      errors++;
      $display("FAIL latency_s8_value: got %h want 11e", {c8, d8});
    end
  endtask

  task automatic test_random;
    logic [9:0] q1 [$];
    logic [9:0] q2 [$];
    logic [9:0] q8 [$];
    logic [9:0] e;
    do_reset();
    for (int cyc = 0; cyc < 340; cyc++) begin
      cycle_start();
      if (cyc < 320) begin
        valid = ($urandom_range(0, 9) < 7);
        rdy   = ($urandom_range(0, 9) < 7);
      end else begin
        valid = 1'b0;
        rdy   = 1'b1;
      end
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      @(negedge clk);
      if (v1 && rdy) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL rand_s1_extra: got %h want none", {c1, d1});
        end else begin
          e = q1.pop_front();
          if ({c1, d1} !== e[8:0]) begin
            errors++;
            $display("FAIL rand_s1: got %h want %h", {c1, d1}, e[8:0]);
          end
`ifdef PIPE_ADDER_OVF_EN
          else if (ovf1 !== e[9]) begin
            errors++;
            $display("FAIL rand_s1_ovf: got %b want %b", ovf1, e[9]);
          end
`endif
        end
      end
      if (v2 && rdy) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL rand_s2_extra: got %h want none", {c2, d2});
        end else begin
          e = q2.pop_front();
          if ({c2, d2} !== e[8:0]) begin
            errors++;
            $display("FAIL rand_s2: got %h want %h", {c2, d2}, e[8:0]);
          end
`ifdef PIPE_ADDER_OVF_EN
          else if (ovf2 !== e[9]) begin
            errors++;
            $display("FAIL rand_s2_ovf: got %b want %b", ovf2, e[9]);
          end
`endif
        end
      end
      if (v8 && rdy) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL rand_s8_extra: got %h want none", {c8, d8});
        end else begin
          e = q8.pop_front();
          if ({c8, d8} !== e[8:0]) begin
            errors++;
            $display("FAIL rand_s8: got %h want %h", {c8, d8}, e[8:0]);
          end
`ifdef PIPE_ADDER_OVF_EN
          else if (ovf8 !== e[9]) begin
            errors++;
            $display("FAIL rand_s8_ovf: got %b want %b", ovf8, e[9]);
          end
`endif
        end
      end
      if (valid && r1) q1.push_back(ref_add(a, b, cin, sub));
      if (valid && r2) q2.push_back(ref_add(a, b, cin, sub));
      if (valid && r8) q8.push_back(ref_add(a, b, cin, sub));
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d/%0d/%0d left want 0/0/0",
               q1.size(), q2.size(), q8.size());
    end
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    rdy   = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    sub   = 1'b0;
    test_reset();
    test_add();
    test_wrap();
    test_sub();
    test_back_to_back_stall();
    test_reset_in_flight();
    test_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..64).
REQ-002 SHALL have parameter STAGES, default 2, number of pipeline stages (legal range 1..WIDTH; WIDTH % STAGES == 0).
REQ-003 SHALL have port iClk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port iRst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port iValid, input, 1, input operands present this cycle.
REQ-006 SHALL have port oReady, output, 1, block accepts input this cycle.
REQ-007 SHALL have port iData_a, input, WIDTH, operand A.
REQ-008 SHALL have port iData_b, input, WIDTH, operand B.
REQ-009 SHALL have port iC, input, 1, carry-in.
REQ-010 SHALL have port iSub, input, 1, mode: 0 = add, 1 = subtract (B inverted).
REQ-011 SHALL have port oValid, output, 1, result present.
REQ-012 SHALL have port iReady, input, 1, downstream accepts result.
REQ-013 SHALL have port oData, output, WIDTH, sum/difference.
REQ-014 SHALL have port oData_C, output, 1, carry-out of MSB.

Function
REQ-015 SHALL compute {oData_C, oData} = iData_a + (iSub ? ~iData_b : iData_b) + iC, modulo 2^(WIDTH+1); iSub=1 with iC=1 gives A-B, where oData_C=1 means no borrow.
REQ-016 SHALL split operands into STAGES chunks of CHUNK=WIDTH/STAGES bits; stage k adds chunk k (LSB first) using the registered carry from stage k-1; stage 0 uses iC.
REQ-017 SHALL carry not-yet-added upper chunks of A and effective-B forward with each stage, and completed lower sum chunks forward, so results stay aligned.
REQ-018 SHALL produce each result exactly STAGES cycles after acceptance when not stalled (STAGES=1: registered adder, latency 1).
REQ-019 SHALL accept input on a cycle where iValid && oReady; SHALL deliver output on a cycle where oValid && iReady.
REQ-020 SHALL use a global advance: advance = !oValid || iReady; oReady = advance; all stages shift only when advance=1.
REQ-021 SHALL hold oData, oData_C and oValid stable while oValid=1 and iReady=0.
REQ-022 SHALL insert a bubble (stage valid=0) when advance=1 and iValid=0; bubbles SHALL NOT raise oValid.
REQ-023 SHALL sustain one result per cycle when iValid=1 and iReady=1 continuously.
REQ-024 SHALL ignore iData_a/iData_b/iC/iSub when not accepting.
REQ-025 SHALL preserve order: results leave in acceptance order, none dropped or duplicated.
REQ-026 SHALL wrap without error: all-ones + 1 gives oData=0, oData_C=1.

Reset
REQ-027 SHALL, on a clock edge with iRst=1, clear all stage valid bits, oValid=0, oData=0, oData_C=0 (and oOvf=0 when present).
REQ-028 SHALL discard in-flight operations on reset mid-operation; no result from before reset SHALL appear afterward.
REQ-029 SHALL drive oReady=1 on the first cycle after reset deasserts.
REQ-030 SHALL ignore iValid on cycles with iRst=1.

Configuration
REQ-031 SHALL, with macro PIPE_ADDER_OVF_EN defined, add output port oOvf (1 bit), signed two's-complement overflow = (A[MSB] == effB[MSB]) && (oData[MSB] != A[MSB]), aligned and held with oData.
REQ-032 SHALL, without PIPE_ADDER_OVF_EN, omit oOvf and all overflow logic; all other behaviour is identical.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-033 SHALL verify: A=0x3C, B=0x15, iC=0, iSub=0, iReady=1 -> 2 cycles later oValid=1, oData=0x51, oData_C=0.
REQ-034 SHALL verify: A=0xFF, B=0x01, iC=0, add -> oData=0x00, oData_C=1; with OVF_EN, A=0x7F, B=0x01 -> oData=0x80, oOvf=1.
REQ-035 SHALL verify: A=0x10, B=0x20, iSub=1, iC=1 -> oData=0xF0, oData_C=0 (borrow).
REQ-036 SHALL verify: 4 back-to-back inputs, iReady=0 for 3 cycles after first oValid -> oReady=0 while full, outputs held, then all 4 results in order.
REQ-037 SHALL verify: iRst=1 with 2 operations in flight -> next cycle oValid=0, oData=0, oReady=1; no stale result ever emitted.
REQ-038 SHALL verify: STAGES=1 and STAGES=8 (WIDTH=8), random operands with random iValid/iReady -> results match reference sum in order, latency equals STAGES when unstalled.
